// File: rtl/cla_pkg.sv
// cla_pkg
//   Shared definitions for the pipelined carry-lookahead adder.
//   - cla_ngrp():  number of lookahead groups (= pipeline stages = latency)
//   - cla_legal(): WIDTH/GROUP legality test, used for an elaboration error
//   - stage_ctrl_t: per-stage control record (valid, subtract flag, carry)
package cla_pkg;

   localparam int CLA_DEF_WIDTH = 16;
   localparam int CLA_DEF_GROUP = 4;

   // Number of stages; guarded so an illegal GROUP=0 does not divide by zero
   // before the legality check gets to report it.
   function automatic int cla_ngrp(input int width, input int group);
      return (group > 0) ? (width / group) : 1;
   endfunction

   function automatic bit cla_legal(input int width, input int group);
      return (group > 0) && (width >= group) && ((width % group) == 0);
   endfunction

   // Control part of a stage record; the data part (partial sum and the
   // remaining operand bits) depends on WIDTH and is completed in the top.
   typedef struct packed {
      logic vld;    // beat valid
      logic sub;    // beat is a subtraction
      logic carry;  // carry into the next group
   } stage_ctrl_t;

endpackage : cla_pkg

// File: rtl/cla_pipe_adder_if.sv
// cla_pipe_adder_if
//   Valid/ready stream bundle for cla_pipe_adder.
//   Input side : in_valid, in_ready, a, b, cin, sub
//   Output side: out_valid, out_ready, sum, cout, ovf
//   master = producer/consumer around the adder, slave = the adder itself.
interface cla_pipe_adder_if #(
   parameter int WIDTH = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface : cla_pipe_adder_if

// File: rtl/cla_group.sv
// cla_group
//   Combinational GROUP-bit carry-lookahead cell.
//   Ports: p, g     propagate / generate per bit
//          cin      carry into bit 0
//          s        sum bits
//          cout     carry out of the top bit
//          c_msb_in carry into the top bit (for signed overflow)
//   Every carry is a flattened sum of products of p, g and cin; there is
//   no ripple chain from one bit's carry to the next.
module cla_group #(
   parameter int GROUP = 4
) (
   input  logic [GROUP-1:0] p,
   input  logic [GROUP-1:0] g,
   input  logic             cin,
   output logic [GROUP-1:0] s,
   output logic             cout,
   output logic             c_msb_in
);

   logic [GROUP:0] c;

   // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin, built from the
   // primary inputs only.
   function automatic logic cla_carry(input logic [GROUP-1:0] pp,
                                      input logic [GROUP-1:0] gg,
                                      input logic             ci,
                                      input int               i);
      logic carry;
      logic term;
      carry = ci;
      for (int m = 0; m <= i; m++) carry &= pp[m];
      for (int j = 0; j <= i; j++) begin
         term = gg[j];
         for (int m = j + 1; m <= i; m++) term &= pp[m];
         carry |= term;
      end
      return carry;
   endfunction

   assign c[0] = cin;

   for (genvar i = 0; i < GROUP; i++) begin : g_carry
      assign c[i+1] = cla_carry(p, g, cin, i);
   end

   assign s        = p ^ c[GROUP-1:0];
   assign cout     = c[GROUP];
   assign c_msb_in = c[GROUP-1];

endmodule : cla_group

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder
//   Pipelined carry-lookahead adder/subtractor, one GROUP-bit group per
//   stage, latency NGRP = WIDTH/GROUP cycles, throughput one beat/cycle.
//   Ports: clk  rising-edge clock
//          rst  synchronous active-high reset (flushes all beats)
//          bus  cla_pipe_adder_if.slave stream bundle
//   Build option: define CLA_PIPE_SAT_EN to clamp the sum to the signed
//   limit on overflow; otherwise the sum wraps modulo 2^WIDTH.
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_DEF_WIDTH,
   parameter int GROUP = CLA_DEF_GROUP
) (
   input  logic             clk,
   input  logic             rst,
   cla_pipe_adder_if.slave  bus
);

   localparam int NGRP = cla_ngrp(WIDTH, GROUP);

   if (!cla_legal(WIDTH, GROUP)) begin : g_bad_cfg
      $error("cla_pipe_adder: WIDTH must be a multiple of GROUP and >= GROUP");
   end

   // Stage record. a_rem/b_rem hold the operands shifted so the group
   // handled by the receiving stage sits in the low GROUP bits; b_rem is
   // already inverted for subtraction.
   typedef struct packed {
      stage_ctrl_t      ctrl;
      logic [WIDTH-1:0] psum;
      logic [WIDTH-1:0] a_rem;
      logic [WIDTH-1:0] b_rem;
   } stage_t;

   stage_t stg_q  [NGRP];
   stage_t stg_d  [NGRP];
   stage_t stg_in [NGRP];

   logic [NGRP-1:0][GROUP-1:0] grp_p;
   logic [NGRP-1:0][GROUP-1:0] grp_g;
   logic [NGRP-1:0][GROUP-1:0] grp_s;
   logic [NGRP-1:0]            grp_cin;
   logic [NGRP-1:0]            grp_cout;
   logic [NGRP-1:0]            grp_cmsb;

   logic cout_q, cout_d;
   logic ovf_q,  ovf_d;
   logic adv;

   // The whole pipeline moves together; an empty or draining output slot
   // lets every stage advance.
   assign adv          = !stg_q[NGRP-1].ctrl.vld || bus.out_ready;
   assign bus.in_ready = adv;

   // Stage inputs and per-group propagate/generate.
   always_comb begin
      // NOTE: every variable gets a full default at the top of a
      // combinational block so no path can leave it unassigned (no latch).
      stg_in[0]            = '0;
      stg_in[0].ctrl.vld   = bus.in_valid;
      stg_in[0].ctrl.sub   = bus.sub;
      stg_in[0].ctrl.carry = bus.sub ? 1'b1 : bus.cin;
      stg_in[0].a_rem      = bus.a;
      stg_in[0].b_rem      = bus.sub ? ~bus.b : bus.b;
      for (int k = 1; k < NGRP; k++) stg_in[k] = stg_q[k-1];
      for (int k = 0; k < NGRP; k++) begin
         grp_p[k]   = stg_in[k].a_rem[GROUP-1:0] ^ stg_in[k].b_rem[GROUP-1:0];
         grp_g[k]   = stg_in[k].a_rem[GROUP-1:0] & stg_in[k].b_rem[GROUP-1:0];
         grp_cin[k] = stg_in[k].ctrl.carry;
      end
   end

   for (genvar k = 0; k < NGRP; k++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
         .p        (grp_p[k]),
         .g        (grp_g[k]),
         .cin      (grp_cin[k]),
         .s        (grp_s[k]),
         .cout     (grp_cout[k]),
         .c_msb_in (grp_cmsb[k])
      );
   end

   // Final-stage flags: the last group owns the MSB.
   assign cout_d = grp_cout[NGRP-1];
   assign ovf_d  = grp_cmsb[NGRP-1] ^ grp_cout[NGRP-1];

   // Next stage records.
   always_comb begin
      for (int k = 0; k < NGRP; k++) begin
         stg_d[k]                         = stg_in[k];
         stg_d[k].ctrl.carry              = grp_cout[k];
         stg_d[k].psum[k*GROUP +: GROUP]  = grp_s[k];
         stg_d[k].a_rem                   = stg_in[k].a_rem >> GROUP;
         stg_d[k].b_rem                   = stg_in[k].b_rem >> GROUP;
      end
`ifdef CLA_PIPE_SAT_EN
      // Overflow means both operands (after b inversion) share a sign, so
      // a's sign picks the limit.
      if (ovf_d) begin
         stg_d[NGRP-1].psum = stg_in[NGRP-1].a_rem[GROUP-1]
                              ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the stage data is reset as well as the valid bits because
         // the last stage drives sum, which must read 0 out of reset.
         for (int k = 0; k < NGRP; k++) stg_q[k] <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (adv) begin
         // NOTE: non-blocking assignments so every stage samples the value
         // its neighbour held before this edge.
         for (int k = 0; k < NGRP; k++) stg_q[k] <= stg_d[k];
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
      end
   end

   assign bus.out_valid = stg_q[NGRP-1].ctrl.vld;
   assign bus.sum       = stg_q[NGRP-1].psum;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;

endmodule : cla_pipe_adder

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder
//   Directed testbench for cla_pipe_adder at WIDTH=16, GROUP=4 (latency 4).
//   Expected values are hand-computed; with CLA_PIPE_SAT_EN defined the
//   overflowing cases expect the clamped sum.
module tb_cla_pipe_adder;

   localparam int W = 16;
`ifdef CLA_PIPE_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   cla_pipe_adder_if #(.WIDTH(W)) bus ();

   cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; land 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected sum: wrap value, or the signed limit when saturating.
   function automatic logic [W-1:0] exp_sum(input logic [W-1:0] a_i,
                                            input logic [W-1:0] wrap,
                                            input logic         ovf_i);
      if (SAT && ovf_i) return a_i[W-1] ? 16'h8000 : 16'h7FFF;
      return wrap;
   endfunction

   task automatic run_single(input string      name,
                             input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                             input logic cin_i, input logic sub_i,
                             input logic [W-1:0] wrap_i,
                             input logic ec, input logic eo);
      int lat;
      logic [W-1:0] es;
      es            = exp_sum(a_i, wrap_i, eo);
      bus.a         = a_i;
      bus.b         = b_i;
      bus.cin       = cin_i;
      bus.sub       = sub_i;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      step();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
         step();
         lat++;
      end
      tests_run++;
      if (lat !== 4) begin
         tests_failed++;
         $display("FAIL %s latency: got %0d cycles, want 4", name, lat);
      end
      tests_run++;
      if ({bus.sum, bus.cout, bus.ovf} !== {es, ec, eo}) begin
         tests_failed++;
         $display("FAIL %s result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                  name, bus.sum, bus.cout, bus.ovf, es, ec, eo);
      end
      step();
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
      rst = 1'b1;
      step();
      step();
      tests_run++;
      if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got out_valid=%b sum=%h cout=%b ovf=%b, want all 0",
                  bus.out_valid, bus.sum, bus.cout, bus.ovf);
      end
      rst = 1'b0;
      step();
      tests_run++;
      if (bus.in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_in_ready: got %b, want 1", bus.in_ready);
      end
   endtask

   task automatic test_carry_chain();
      run_single("carry_all_groups", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_single("add_with_cin",     16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
   endtask

   task automatic test_overflow();
      run_single("pos_overflow", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_single("neg_overflow", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
   endtask

   task automatic test_subtract();
      run_single("sub_borrow",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_single("sub_overflow", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
   endtask

   task automatic test_back_to_back();
      // {a, b, cin, sub, wrapped sum, cout, ovf}
      logic [W-1:0] va [8] = '{16'h0001, 16'h00FF, 16'h1000, 16'hFFFF,
                               16'h4000, 16'hABCD, 16'h0F0F, 16'h8000};
      logic [W-1:0] vb [8] = '{16'h0002, 16'h0001, 16'h2000, 16'hFFFF,
                               16'h4000, 16'h1111, 16'hF0F0, 16'h7FFF};
      logic         vc [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic         vs [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [W-1:0] ew [8] = '{16'h0003, 16'h0101, 16'hF000, 16'hFFFE,
                               16'h8000, 16'h9ABC, 16'h0000, 16'h0001};
      logic         ec [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic         eo [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      int idx = 0;
      int oidx = 0;
      int last_fire = -1;
      logic [W+1:0] held = '0;
      logic [W-1:0] es;
      for (int cyc = 0; cyc < 40 && oidx < 8; cyc++) begin
         bus.out_ready = !(cyc >= 6 && cyc <= 8);
         bus.in_valid  = (idx < 8);
         if (idx < 8) begin
            bus.a = va[idx]; bus.b = vb[idx]; bus.cin = vc[idx]; bus.sub = vs[idx];
         end
         #1;
         if (cyc >= 6 && cyc <= 8) begin
            tests_run++;
            if (bus.in_ready !== 1'b0) begin
               tests_failed++;
               $display("FAIL stall_in_ready cycle %0d: got %b, want 0", cyc, bus.in_ready);
            end
            if (cyc == 6) held = {bus.sum, bus.cout, bus.ovf};
            else begin
               tests_run++;
               if ({bus.sum, bus.cout, bus.ovf} !== held) begin
                  tests_failed++;
                  $display("FAIL stall_hold cycle %0d: got %h, want %h",
                           cyc, {bus.sum, bus.cout, bus.ovf}, held);
               end
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            es = exp_sum(va[oidx], ew[oidx], eo[oidx]);
            tests_run++;
            if ({bus.sum, bus.cout, bus.ovf} !== {es, ec[oidx], eo[oidx]}) begin
               tests_failed++;
               $display("FAIL stream_beat%0d: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                        oidx, bus.sum, bus.cout, bus.ovf, es, ec[oidx], eo[oidx]);
            end
            oidx++;
            last_fire = cyc;
         end
         if (bus.in_valid && bus.in_ready) idx++;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tests_run++;
      if (oidx !== 8 || last_fire !== 14) begin
         tests_failed++;
         $display("FAIL stream_throughput: got %0d beats, last at cycle %0d, want 8 beats, last at cycle 14",
                  oidx, last_fire);
      end
      step();
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL stream_no_duplicate: got out_valid=%b after last beat, want 0", bus.out_valid);
      end
   endtask

   task automatic test_flush();
      logic [W-1:0] fa [3] = '{16'h1111, 16'h2222, 16'h3333};
      int fires = 0;
      logic [W+1:0] got = '0;
      bus.out_ready = 1'b1;
      bus.b = 16'h0001; bus.cin = 1'b0; bus.sub = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.a = fa[i];
         bus.in_valid = 1'b1;
         step();
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      step();
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_out_valid: got %b, want 0", bus.out_valid);
      end
      rst = 1'b0;
      bus.a = 16'h0100; bus.b = 16'h0023; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (bus.out_valid) begin
            fires++;
            got = {bus.sum, bus.cout, bus.ovf};
         end
         step();
      end
      tests_run++;
      if (fires !== 1 || got !== {16'h0123, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL flush_post_reset: got %0d beats, last %h, want 1 beat %h",
                  fires, got, {16'h0123, 1'b0, 1'b0});
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      test_reset();
      test_carry_chain();
      test_overflow();
      test_subtract();
      test_back_to_back();
      test_flush();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_cla_pipe_adder
